// File: rtl/div_man_iter_if.sv
// Handshake and operand/result bundle for the iterative mantissa divider.
// The master side issues start and operands; the slave side returns the
// registered quotient, flags and status.
interface div_man_iter_if #(
    parameter int SIZE_DATA = 24
);
    logic                 i_start;
    logic [SIZE_DATA-1:0] i_data_a;
    logic [SIZE_DATA-1:0] i_data_b;
    logic                 o_busy;
    logic                 o_valid;
    logic [SIZE_DATA-1:0] o_data_div;
    logic                 o_norm_flag;
    logic                 o_rounding;
    logic                 o_div_zero;

    modport master (
        output i_start, i_data_a, i_data_b,
        input  o_busy, o_valid, o_data_div, o_norm_flag, o_rounding, o_div_zero
    );

    modport slave (
        input  i_start, i_data_a, i_data_b,
        output o_busy, o_valid, o_data_div, o_norm_flag, o_rounding, o_div_zero
    );
endinterface

// File: rtl/div_man_iter.sv
// Iterative radix-2 restoring mantissa divider, one quotient bit per clock.
// Produces SIZE_DATA+3 quotient bits (integer bit plus fraction incl. guard
// and round), then normalizes and forms the guard/round/sticky round-up flag.
// Optional feature macro: DIV_EARLY_TERM_EN -- stop iterating as soon as the
// partial remainder reaches zero and zero-fill the remaining quotient bits.
module div_man_iter #(
    parameter int SIZE_DATA = 24
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    div_man_iter_if.slave  bus
);
    localparam int QW = SIZE_DATA + 3;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r, state_nxt;
    logic [SIZE_DATA:0]   rem_r;
    logic [SIZE_DATA-1:0] div_r;
    logic [QW-2:0]        quo_r;      // bits gathered before the final step
    logic [CW-1:0]        cnt_r;
    logic                 dz_r;

    logic                 busy_r, valid_r, norm_r, rnd_r, dzo_r;
    logic [SIZE_DATA-1:0] mant_r;

    logic                 ge_s;
    logic [SIZE_DATA-1:0] rem_sub_s;
    logic [SIZE_DATA:0]   rem_step_s;
    logic [QW-1:0]        quo_step_s;
    logic [QW-1:0]        q_fin_s;
    logic                 accept_s, finish_s;
    logic [SIZE_DATA+1:0] result_s;

    // Normalize the raw quotient and derive {norm_flag, rounding, mantissa}.
    function automatic logic [SIZE_DATA+1:0] form_result(input logic [QW-1:0] q,
                                                         input logic rem_nz);
        logic g, r, s;
        if (q[QW-1]) begin
            g = q[2];
            r = q[1];
            s = rem_nz | q[0];
            form_result = {1'b0, g & (r | s), q[QW-1:3]};
        end else begin
            g = q[1];
            r = q[0];
            s = rem_nz;
            form_result = {1'b1, g & (r | s), q[QW-2:2]};
        end
    endfunction

    // One restoring step; R < 2b keeps the difference inside SIZE_DATA bits.
    always_comb begin
        ge_s       = (rem_r >= {1'b0, div_r});
        rem_sub_s  = rem_r[SIZE_DATA-1:0] - div_r;
        rem_step_s = ge_s ? {rem_sub_s, 1'b0} : {rem_r[SIZE_DATA-1:0], 1'b0};
        quo_step_s = {quo_r, ge_s};
    end

    // Next-state decode, operand accept and final-iteration detection.
    always_comb begin
        state_nxt = state_r;
        accept_s  = 1'b0;
        finish_s  = 1'b0;
        q_fin_s   = quo_step_s;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = ST_CALC;
                    accept_s  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (dz_r) begin
                    state_nxt = ST_DONE;
                    finish_s  = 1'b1;
                end else if (cnt_r == LAST_ITER) begin
                    state_nxt = ST_DONE;
                    finish_s  = 1'b1;
`ifdef DIV_EARLY_TERM_EN
                end else if (rem_step_s == '0) begin
                    state_nxt = ST_DONE;
                    finish_s  = 1'b1;
                    q_fin_s   = quo_step_s << (LAST_ITER - cnt_r);
`endif
                end else begin
                    state_nxt = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.i_start) begin
                    state_nxt = ST_CALC;
                    accept_s  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        result_s = form_result(q_fin_s, rem_step_s != '0);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath: capture operands on accept, otherwise iterate while in CALC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_r <= '0;
            div_r <= '0;
            quo_r <= '0;
            cnt_r <= '0;
            dz_r  <= 1'b0;
        end else if (accept_s) begin
            rem_r <= {1'b0, bus.i_data_a};
            div_r <= bus.i_data_b;
            quo_r <= '0;
            cnt_r <= '0;
            dz_r  <= (bus.i_data_b == '0);
        end else if (state_r == ST_CALC && !dz_r) begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s[QW-2:0];
            cnt_r <= cnt_r + CW'(1);
        end else begin
            rem_r <= rem_r;
        end
    end

    // Output registers: status every cycle, result only on entry to DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            mant_r  <= '0;
            norm_r  <= 1'b0;
            rnd_r   <= 1'b0;
            dzo_r   <= 1'b0;
        end else begin
            busy_r  <= (state_nxt != ST_IDLE);
            valid_r <= finish_s;
            if (finish_s && dz_r) begin
                mant_r <= '1;
                norm_r <= 1'b0;
                rnd_r  <= 1'b0;
                dzo_r  <= 1'b1;
            end else if (finish_s) begin
                mant_r <= result_s[SIZE_DATA-1:0];
                rnd_r  <= result_s[SIZE_DATA];
                norm_r <= result_s[SIZE_DATA+1];
                dzo_r  <= 1'b0;
            end else begin
                mant_r <= mant_r;
            end
        end
    end

    assign bus.o_busy      = busy_r;
    assign bus.o_valid     = valid_r;
    assign bus.o_data_div  = mant_r;
    assign bus.o_norm_flag = norm_r;
    assign bus.o_rounding  = rnd_r;
    assign bus.o_div_zero  = dzo_r;
endmodule

// File: tb/tb_div_man_iter.sv
// Self-checking bench for div_man_iter: directed cases with literal
// expectations plus randomized operands checked against an arithmetic model.
module tb_div_man_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    div_man_iter_if #(.SIZE_DATA(24)) bus();

    div_man_iter #(.SIZE_DATA(24)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Count rising edges so latency can be measured in clocks.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] m;
        logic        nf;
        logic        rd;
        logic        dz;
        int          lat;
        int          acc;
        bit          lit;
        logic [23:0] lm;
        logic        lnf;
        logic        lrd;
    } exp_t;

    exp_t pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Quotient from plain integer division of a*2^26 by b.
    function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                  output logic [23:0] m, output logic nf,
                                  output logic rd, output logic dz, output int lat);
        longint unsigned num, q, r;
        logic g, rr, s;
        if (b == 24'h0) begin
            m = 24'hFFFFFF; nf = 1'b0; rd = 1'b0; dz = 1'b1; lat = 1;
            return;
        end
        num = longint'(a) << 26;
        q = num / longint'(b);
        r = num % longint'(b);
        dz = 1'b0;
        if (q >= 64'd67108864) begin
            m = q[26:3]; g = q[2]; rr = q[1]; s = (r != 0) | q[0]; nf = 1'b0;
        end else begin
            m = q[25:2]; g = q[1]; rr = q[0]; s = (r != 0); nf = 1'b1;
        end
        rd = g & (rr | s);
        lat = 27;
`ifdef DIV_EARLY_TERM_EN
        for (int i = 1; i <= 27; i++) begin
            if (((longint'(a) << (i - 1)) % longint'(b)) == 0) begin
                lat = i;
                break;
            end
        end
`endif
    endfunction

    // Compare every valid result against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_valid) begin
            if (pend.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = pend.pop_front();
                check("mant", {8'h0, bus.o_data_div}, {8'h0, e.m});
                check("norm", {31'h0, bus.o_norm_flag}, {31'h0, e.nf});
                check("round", {31'h0, bus.o_rounding}, {31'h0, e.rd});
                check("divzero", {31'h0, bus.o_div_zero}, {31'h0, e.dz});
                check("busy_in_done", {31'h0, bus.o_busy}, 32'd1);
                check("latency", cyc - e.acc, e.lat);
                if (e.lit) begin
                    check("lit_mant", {8'h0, bus.o_data_div}, {8'h0, e.lm});
                    check("lit_norm", {31'h0, bus.o_norm_flag}, {31'h0, e.lnf});
                    check("lit_round", {31'h0, bus.o_rounding}, {31'h0, e.lrd});
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (pend.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (pend.size() != 0) begin
            check("timeout", 32'd1, 32'd0);
            pend.delete();
        end
    endtask

    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input bit lit,
                         input logic [23:0] lm, input logic lnf, input logic lrd);
        exp_t e;
        @(negedge clk); #1;
        wait_idle();
        model(a, b, e.m, e.nf, e.rd, e.dz, e.lat);
        e.lit = lit; e.lm = lm; e.lnf = lnf; e.lrd = lrd;
        e.acc = cyc + 1;
        bus.i_start = 1'b1;
        bus.i_data_a = a;
        bus.i_data_b = b;
        pend.push_back(e);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    initial begin
        int seen;
        logic [23:0] ra, rb;
        bus.i_start = 1'b0;
        bus.i_data_a = 24'h0;
        bus.i_data_b = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, bus.o_valid}, 32'd0);
        check("rst_busy", {31'h0, bus.o_busy}, 32'd0);
        check("rst_mant", {8'h0, bus.o_data_div}, 32'd0);
        rst_n = 1'b1;

        do_op(24'h800000, 24'h800000, 1'b1, 24'h800000, 1'b0, 1'b0);
        do_op(24'hC00000, 24'h800000, 1'b1, 24'hC00000, 1'b0, 1'b0);
        do_op(24'h800000, 24'hC00000, 1'b1, 24'hAAAAAA, 1'b1, 1'b1);
        do_op(24'h900000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        do_op(24'h000000, 24'hA00000, 1'b1, 24'h000000, 1'b1, 1'b0);
        wait_idle();

        // Start pulse while busy must be ignored.
        do_op(24'h800000, 24'hC00000, 1'b1, 24'hAAAAAA, 1'b1, 1'b1);
        repeat (4) @(negedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_data_a = 24'hF00000;
        bus.i_data_b = 24'h000000;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset in the middle of a calculation.
        do_op(24'h800000, 24'hC00000, 1'b0, 24'h0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'h0, bus.o_valid}, 32'd0);
        check("abort_busy", {31'h0, bus.o_busy}, 32'd0);
        check("abort_mant", {8'h0, bus.o_data_div}, 32'd0);
        check("abort_norm", {31'h0, bus.o_norm_flag}, 32'd0);
        check("abort_round", {31'h0, bus.o_rounding}, 32'd0);
        pend.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        do_op(24'hC00000, 24'h800000, 1'b1, 24'hC00000, 1'b0, 1'b0);

        // Randomized operands, issued back to back as soon as each result lands.
        for (int i = 0; i < 40; i++) begin
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            if ($urandom_range(0, 9) == 0) rb = 24'h0;
            if ($urandom_range(0, 9) == 0) ra = 24'h0;
            if ($urandom_range(0, 7) == 0) ra = rb;
            do_op(ra, rb, 1'b0, 24'h0, 1'b0, 1'b0);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
